aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter_pkg.sv | 39 +++
 rtl/aes_decrypt_iter_if.sv | 24 ++
 rtl/aes_decrypt_iter_inv_round.sv | 66 ++++++
 rtl/aes_decrypt_iter.sv | 82 ++++++++
 tb/tb_aes_decrypt_iter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_decrypt_iter_pkg.sv
// Shared AES-128 decrypt definitions: FSM states, sizes, inverse S-box and
// the GF(2^8) doubling primitive used to build the InvMixColumns multipliers.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 1408;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x (02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Request/response bundle between a ciphertext producer and the decrypt core.
interface aes_decrypt_iter_if;
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [127:0]     cipher_text;
  logic [KEY_W-1:0] expanded_key;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     plain_text;
  logic             busy;

  modport slave (
    input  in_valid, cipher_text, expanded_key, out_ready,
    output in_ready, out_valid, plain_text, busy
  );

  modport master (
    output in_valid, cipher_text, expanded_key, out_ready,
    input  in_ready, out_valid, plain_text, busy
  );

endinterface

// File: rtl/aes_decrypt_iter_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and, unless is_final, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output logic [127:0] state_out
);

  logic [127:0] shift_sub;
  logic [127:0] added;
  logic [127:0] mixed;

  // Multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = gf_mul2(a);
    x4 = gf_mul2(x2);
    x8 = gf_mul2(x4);
    return (coef[0] ? a : 8'h00) ^ (coef[1] ? x2 : 8'h00) ^
           (coef[2] ? x4 : 8'h00) ^ (coef[3] ? x8 : 8'h00);
  endfunction

  // One column; byte 0 of the column (row 0) sits in bits [7:0].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^ gf_mul_c(a3, 4'he),
            gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^ gf_mul_c(a3, 4'hb),
            gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^ gf_mul_c(a3, 4'hd),
            gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^ gf_mul_c(a3, 4'h9)};
  endfunction

  // Row r rotates right by r columns, then each byte goes through the inverse S-box.
  always_comb begin
    shift_sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_sub[8*(r+4*c) +: 8] = INV_SBOX[state_in[8*(r+4*((c-r+4)%4)) +: 8]];
      end
    end
  end

  assign added = shift_sub ^ round_key;

  // Column-wise InvMixColumns on the key-added state.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = inv_mix_col(added[32*c +: 32]);
    end
  end

  assign state_out = is_final ? added : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, key schedule
// supplied pre-expanded by the producer and held stable during the operation.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  aes_decrypt_iter_if.slave bus
);

  state_t       state;
  state_t       state_nx;
  logic [3:0]   rnd;
  logic [127:0] state_reg;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic         accept;

  assign accept = bus.in_valid && (state == S_IDLE);

  // Round-key mux: rnd selects one 128-bit slice of the expanded schedule.
  always_comb begin
    round_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rnd == 4'(i)) round_key = bus.expanded_key[128*i +: 128];
    end
  end

  aes_inv_round u_inv_round (
    .state_in  (state_reg),
    .round_key (round_key),
    .is_final  (state == S_FINAL),
    .state_out (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; the last full round is the one that consumes key 1.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ROUND;
      S_ROUND: if (rnd == 4'd1) state_nx = S_FINAL;
      S_FINAL: state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: initial whitening with key 10, then one inverse round per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd       <= 4'd0;
      state_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_reg <= bus.cipher_text ^ bus.expanded_key[128*NUM_ROUNDS +: 128];
            rnd       <= 4'(NUM_ROUNDS - 1);
          end
        end
        S_ROUND: begin
          state_reg <= round_out;
          rnd       <= rnd - 4'd1;
        end
        S_FINAL: state_reg <= round_out;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.plain_text = state_reg;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, backpressure, mid-run reset
// and a randomized encrypt/decrypt round trip against a behavioural AES model.
module tb_aes_decrypt_iter;

  localparam int NB = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] model_sbox [256];

  aes_decrypt_iter_if bus ();

  aes_decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generic GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      model_sbox[x] = b;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [7:0]    w [176];
    logic [7:0]    t [4];
    logic [7:0]    tmp;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int j = 0; j < 16; j++) w[j] = key[8*j +: 8];
    for (int j = 16; j < 176; j += 4) begin
      for (int n = 0; n < 4; n++) t[n] = w[j-4+n];
      if (j % 16 == 0) begin
        tmp  = t[0];
        t[0] = model_sbox[t[1]] ^ rc;
        t[1] = model_sbox[t[2]];
        t[2] = model_sbox[t[3]];
        t[3] = model_sbox[tmp];
        rc   = gmul(rc, 8'h02);
      end
      for (int n = 0; n < 4; n++) w[j+n] = w[j-16+n] ^ t[n];
    end
    for (int j = 0; j < 176; j++) res[8*j +: 8] = w[j];
    return res;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ ek[8*k +: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) s[k] = model_sbox[s[k]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) t[row+4*c] = s[row+4*((c+row)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ ek[128*rd + 8*k +: 8];
    end
    for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one request from IDLE; returns posedges from accept to out_valid.
  task automatic do_request(input logic [127:0] ct, input logic [1407:0] ek,
                            output int lat, output logic [127:0] pt);
    bus.cipher_text  = ct;
    bus.expanded_key = ek;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pt = bus.plain_text;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.cipher_text  = '0;
    bus.expanded_key = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.plain_text !== 128'h0) begin errors++; $display("FAIL reset_plain got %h want 0", bus.plain_text); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_fips_c1();
    logic [1407:0] ek;
    logic [127:0]  pt;
    int            lat;
    ek = expand_key(128'h0f0e0d0c0b0a09080706050403020100);
    bus.out_ready = 1'b1;
    do_request(128'h5ac5b47080b7cdd830047b6ad8e0c469, ek, lat, pt);
    checks++; if (lat !== 10) begin errors++; $display("FAIL c1_latency got %0d want 10", lat); end
    checks++; if (pt !== 128'hffeeddccbbaa99887766554433221100) begin errors++; $display("FAIL c1_plain got %h want ffeeddccbbaa99887766554433221100", pt); end
    checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL c1_done_flags got busy=%b ready=%b want 1/0", bus.busy, bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL c1_one_cycle got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_fips_b();
    logic [1407:0] ek;
    logic [127:0]  pt;
    int            lat;
    ek = expand_key(128'h3c4fcf098815f7aba6d2ae2816157e2b);
    bus.out_ready = 1'b1;
    do_request(128'h320b6a19978511dcfb09dc021d842539, ek, lat, pt);
    checks++; if (lat !== 10) begin errors++; $display("FAIL b_latency got %0d want 10", lat); end
    checks++; if (pt !== 128'h340737e0a29831318d305a88a8f64332) begin errors++; $display("FAIL b_plain got %h want 340737e0a29831318d305a88a8f64332", pt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [1407:0] ek;
    logic [127:0]  pt;
    int            lat;
    int            bad;
    ek = expand_key(128'h0f0e0d0c0b0a09080706050403020100);
    bus.out_ready = 1'b0;
    do_request(128'h5ac5b47080b7cdd830047b6ad8e0c469, ek, lat, pt);
    checks++; if (pt !== 128'hffeeddccbbaa99887766554433221100) begin errors++; $display("FAIL bp_plain got %h want ffeeddccbbaa99887766554433221100", pt); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid    = 1'b1;
      bus.cipher_text = rand128();
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.plain_text !== 128'hffeeddccbbaa99887766554433221100) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b plain=%h want 1/0/ffeeddccbbaa99887766554433221100",
                 i, bus.out_valid, bus.in_ready, bus.plain_text);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_no_queued got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [1407:0] ek;
    logic [127:0]  pt;
    int            lat;
    ek = expand_key(128'h0f0e0d0c0b0a09080706050403020100);
    bus.out_ready    = 1'b1;
    bus.cipher_text  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    bus.expanded_key = ek;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b want 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.plain_text !== 128'h0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_async got valid=%b plain=%h busy=%b ready=%b want 0/0/0/1",
               bus.out_valid, bus.plain_text, bus.busy, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_after_release got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    do_request(128'h5ac5b47080b7cdd830047b6ad8e0c469, ek, lat, pt);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rm_latency got %0d want 10", lat); end
    checks++; if (pt !== 128'hffeeddccbbaa99887766554433221100) begin errors++; $display("FAIL rm_plain got %h want ffeeddccbbaa99887766554433221100", pt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0]  exp_q [$];
    logic [127:0]  pt;
    logic [127:0]  key;
    logic [1407:0] ek;
    logic [127:0]  want;
    logic          prev_ov;
    int            cyc;
    int            n_acc;
    int            n_out;
    int            last_acc;
    cyc      = 0;
    n_acc    = 0;
    n_out    = 0;
    last_acc = -1;
    prev_ov  = 1'b0;
    bus.out_ready = 1'b1;
    while (n_out < NB && cyc < NB * 12 + 100) begin
      if (bus.in_ready === 1'b1) begin
        if (n_acc < NB) begin
          pt  = rand128();
          key = rand128();
          ek  = expand_key(key);
          bus.expanded_key = ek;
          bus.cipher_text  = model_encrypt(pt, ek);
          bus.in_valid     = 1'b1;
          exp_q.push_back(pt);
          if (last_acc >= 0) begin
            checks++;
            if (cyc - last_acc != 12) begin errors++; $display("FAIL b2b_spacing block %0d got %0d want 12", n_acc, cyc - last_acc); end
          end
          last_acc = cyc;
          n_acc++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (prev_ov) begin errors++; $display("FAIL b2b_width block %0d out_valid held 2 cycles want 1", n_out); end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_spurious got out_valid with no request want none");
        end else begin
          want = exp_q.pop_front();
          checks++;
          if (bus.plain_text !== want) begin errors++; $display("FAIL b2b_plain block %0d got %h want %h", n_out, bus.plain_text, want); end
        end
        n_out++;
      end
      prev_ov = bus.out_valid;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n_out != NB) begin errors++; $display("FAIL b2b_timeout got %0d results want %0d", n_out, NB); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
